// File: rtl/sort_ctrl.sv
// Batch sorter: loads N unsigned W-bit values, bubble-sorts them in place using one
// shared comparator (one compare-and-swap per clock), then streams them out smallest first.
module sort_ctrl #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic [7:0]   swap_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);
  localparam logic [IW:0]   LAST_PAIR = (IW + 1)'(N - 2);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] p_q, p_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;
  logic          swapped_q, swapped_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];

  logic [IW-1:0] j_nxt_s;
  logic [W-1:0]  cmp_lo_s, cmp_hi_s;
  logic          do_swap_s, pass_end_s, any_swap_s;

  // Shared comparator on the current pair; end of pass when j reaches N-2-p.
  assign j_nxt_s    = j_q + IW'(1);
  assign cmp_lo_s   = mem_q[j_q];
  assign cmp_hi_s   = mem_q[j_nxt_s];
  assign do_swap_s  = cmp_lo_s > cmp_hi_s;
  assign pass_end_s = ({1'b0, j_q} + {1'b0, p_q}) >= LAST_PAIR;
  assign any_swap_s = swapped_q | do_swap_s;

  // Next-state logic for the LOAD / SORT / DRAIN sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    p_d         = p_q;
    j_d         = j_q;
    k_d         = k_q;
    swapped_d   = swapped_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    mem_d       = mem_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_d[idx_q] = in_data;
          if (idx_q == '0) begin
            cnt_d = 8'd0;
          end else begin
            cnt_d = cnt_q;
          end
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            p_d        = '0;
            j_d        = '0;
            swapped_d  = 1'b0;
            state_d    = S_SORT;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_SORT: begin
        if (do_swap_s) begin
          mem_d[j_q]     = cmp_hi_s;
          mem_d[j_nxt_s] = cmp_lo_s;
          swapped_d      = 1'b1;
          cnt_d          = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (!pass_end_s) begin
          j_d = j_nxt_s;
        end else if (!any_swap_s || p_q == LAST_PASS) begin
          k_d         = '0;
          state_d     = S_DRAIN;
          out_valid_d = 1'b1;
        end else begin
          p_d       = p_q + IW'(1);
          j_d       = '0;
          swapped_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (k_q == LAST_IDX) begin
            k_d         = '0;
            idx_d       = '0;
            state_d     = S_LOAD;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
          end else begin
            k_d = k_q + IW'(1);
          end
        end else begin
          k_d = k_q;
        end
      end
      default: begin
        state_d     = S_LOAD;
        idx_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Control state and registered handshake flags, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      p_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      swapped_q   <= 1'b0;
      cnt_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      p_q         <= p_d;
      j_q         <= j_d;
      k_q         <= k_d;
      swapped_q   <= swapped_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Element storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Flags are forced low while reset is held.
  assign in_ready   = in_ready_q & ~rst;
  assign out_valid  = out_valid_q & ~rst;
  assign busy       = busy_q & ~rst;
  assign out_data   = mem_q[k_q];
  assign swap_count = cnt_q;

endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl: directed test-plan batches plus random batches
// compared against a reference model (insertion sort, inversion count, pass-count rule).
module tb_sort_ctrl;
  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic [7:0]   swap_count;

  sort_ctrl #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int prev_swaps = 0;
  int vec [N];
  int exp_sorted [N];
  int exp_swaps;
  int exp_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: sorted order, swap count = inversions, passes = 1 + max greater-to-left (capped).
  function automatic void build_model();
    int a [N];
    int maxleft;
    int passes;
    int t;
    maxleft   = 0;
    exp_swaps = 0;
    for (int i = 0; i < N; i++) begin
      int left;
      left = 0;
      for (int m = 0; m < i; m++) if (vec[m] > vec[i]) left++;
      exp_swaps += left;
      if (left > maxleft) maxleft = left;
      a[i] = vec[i];
    end
    for (int i = 1; i < N; i++) begin
      for (int m = i; m > 0 && a[m-1] > a[m]; m--) begin
        t = a[m]; a[m] = a[m-1]; a[m-1] = t;
      end
    end
    for (int i = 0; i < N; i++) exp_sorted[i] = a[i];
    passes = (maxleft + 1 < N - 1) ? maxleft + 1 : N - 1;
    exp_cycles = 0;
    for (int p = 0; p < passes; p++) exp_cycles += N - 1 - p;
  endfunction

  task automatic load_batch(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int idle;
        idle = $urandom_range(0, 2);
        in_valid = 1'b0;
        for (int g = 0; g < idle; g++) begin
          chk("load_ready_idle", in_ready, 1);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = W'(vec[i]);
      begin
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
          t++;
          @(negedge clk);
        end
        if (t >= 20) chk("load_timeout", t, 0);
      end
      if (i == 0) chk("swap_count_hold", swap_count, prev_swaps);
      chk("load_busy", busy, 0);
      chk("load_out_valid", out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_sort();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      chk("sort_busy", busy, 1);
      chk("sort_in_ready", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("sort_cycles", n, exp_cycles);
  endtask

  task automatic drain(input int bp_at, input int bp_len, input int tp_swaps);
    chk("swap_count", swap_count, exp_swaps);
    if (tp_swaps >= 0) chk("plan_swap_count", swap_count, tp_swaps);
    for (int k = 0; k < N; k++) begin
      if (k == bp_at) begin
        out_ready = 1'b0;
        for (int b = 0; b < bp_len; b++) begin
          in_valid = 1'($urandom_range(0, 1));
          chk("bp_out_valid", out_valid, 1);
          chk("bp_out_data", out_data, exp_sorted[k]);
          chk("bp_in_ready", in_ready, 0);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      in_valid  = (k == N - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      chk("drain_out_valid", out_valid, 1);
      chk("drain_out_data", out_data, exp_sorted[k]);
      chk("drain_busy", busy, 1);
      chk("drain_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_swap_count", swap_count, exp_swaps);
    prev_swaps = exp_swaps;
  endtask

  task automatic do_batch(input int a, input int b, input int c, input int d,
                          input bit gaps, input int bp_at, input int bp_len,
                          input int tp_swaps, input int tp_cycles);
    vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
    build_model();
    load_batch(gaps);
    run_sort();
    if (tp_cycles >= 0) chk("plan_sort_cycles", exp_cycles, tp_cycles);
    drain(bp_at, bp_len, tp_swaps);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_swap_count", swap_count, 0);

    do_batch(9, 3, 15, 0, 1'b0, -1, 0, 4, 6);
    do_batch(1, 2, 3, 4, 1'b0, -1, 0, 0, 3);
    do_batch(15, 8, 5, 0, 1'b0, -1, 0, 6, 6);
    do_batch(5, 5, 0, 5, 1'b0, -1, 0, 2, -1);
    do_batch(7, 2, 12, 4, 1'b0, 1, 3, -1, -1);

    // Reset mid-SORT after two compares.
    vec[0] = 9; vec[1] = 3; vec[2] = 15; vec[3] = 0;
    load_batch(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("midsort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_swap_count", swap_count, 0);
    prev_swaps = 0;
    do_batch(2, 1, 0, 3, 1'b0, -1, 0, 3, -1);

    for (int r = 0; r < 25; r++) begin
      do_batch(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               1'b1, int'($urandom_range(0, N)), int'($urandom_range(0, 3)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
